rst_sequencer: RTL
==================

// Module: rst_sequencer
// PURPOSE
//  Generates staged, active-low synchronous resets (o_rstn) for downstream
//  register blocks that take an active-low i_rstn. It takes the global
//  synchronous active-high reset and a soft-reset request. It holds all
//  domains in reset, then releases them one at a time in index order.
//  It sits at the top level between global reset and the datapath register banks.
// PARAMETERS
//  N_DOMAINS  4   number of reset outputs (1..16), released in order 0..N-1
//  HOLD_CYC   16  cycles all outputs stay asserted before the first release (>=1)
//  GAP_CYC    4   cycles between consecutive domain releases (>=1)
//  CNT_W      8   counter width; must hold max(HOLD_CYC,GAP_CYC)-1
// PORTS
//  i_clk    in   1          single clock, all logic on posedge
//  i_rst    in   1          synchronous reset, active-high
//  i_req    in   1          soft-reset request, sampled each posedge, level
//  o_rstn   out  N_DOMAINS  per-domain reset to downstream blocks, 0 = in reset
//  o_busy   out  1          1 while any o_rstn bit is 0
//  o_done   out  1          one-cycle pulse on the cycle the last domain releases
// BEHAVIOUR
//  - Interface: one clock i_clk. i_rst is synchronous and active-high; no async path.
//  - All outputs are registered. There is no combinational input-to-output path.
//  - Reset (posedge with i_rst=1) sets:
//    o_rstn = all 0; o_busy = 1; o_done = 0; state = HOLD; cnt = 0; idx = 0.
//  - States: HOLD, REL, RUN.
//  - HOLD: all o_rstn = 0.
//    - cnt increments each edge.
//    - On the edge that sees cnt == HOLD_CYC-1: o_rstn[0] <= 1, cnt <= 0, idx <= 1, go to REL.
//    - If N_DOMAINS == 1, that same edge instead sets o_done <= 1, o_busy <= 0 and goes to RUN.
//  - REL: cnt increments each edge.
//    - On the edge that sees cnt == GAP_CYC-1: o_rstn[idx] <= 1, cnt <= 0, idx <= idx+1.
//    - If idx == N_DOMAINS-1 on that edge, also o_done <= 1, o_busy <= 0 and go to RUN.
//  - RUN: o_rstn = all 1, o_busy = 0. o_done returns to 0 on the next edge.
//  - Timing: let E1 be the first edge that samples i_rst=0.
//    - o_rstn[k] rises after edge E(HOLD_CYC + k*GAP_CYC).
//    - o_done is high for exactly the one cycle following the last release.
//  - Released bits stay 1 until the next restart. Once a bit rises it never glitches low.
//  - Soft reset: any edge sampling i_req=1 with i_rst=0, in any state, does the following:
//    o_rstn <= all 0; o_busy <= 1; o_done <= 0; cnt <= 0; idx <= 0; go to HOLD.
//    - i_req held high keeps the block in HOLD with cnt at 0.
//    - The full HOLD_CYC count restarts from the first edge that samples i_req=0.
//  - Priority: i_rst > i_req > sequencing. An i_req on the final-release edge
//    wins: no o_done, all outputs asserted.
//  - Counters never wrap. cnt clears on every state change. idx is used only in REL.
// TESTING
//  1. Power-up: i_rst=1 for 3 cycles, then 0.
//     -> o_rstn=4'b0000 through E15; 4'b0001 after E16, 4'b0011 after E20,
//        4'b0111 after E24, 4'b1111 after E28.
//     -> o_done=1 only in the cycle after E28; o_busy falls after E28.
//  2. Soft reset in RUN: i_req=1 for 1 cycle.
//     -> o_rstn=0 and o_busy=1 after that edge; the release sequence repeats
//        with the same 16/4 spacing from the first edge sampling i_req=0.
//  3. i_req mid-release: pulse i_req when o_rstn=4'b0011.
//     -> o_rstn=4'b0000 after that edge; no o_done until the full sequence completes.
//  4. i_rst mid-sequence while o_rstn=4'b0111.
//     -> all outputs return to reset values on that edge; the sequence restarts as in test 1.
//  5. Collision: i_req=1 on edge E28.
//     -> o_rstn stays 4'b0000 after E28 (bit 3 never rises); o_done stays 0; o_busy stays 1.
//  6. Parameter sweep N_DOMAINS=1, HOLD_CYC=1, GAP_CYC=1.
//     -> o_rstn[0] rises after E1, o_done pulses in the same cycle, busy falls after E1.

Source files
------------

// File: rtl/rst_sequencer.sv
// Staged reset release: holds every downstream domain in reset, then lets
// them out one at a time in index order, with a soft-reset request that
// restarts the whole sequence from any point.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HOLD  | all domains in reset, counting the initial hold period
//   REL   | releasing domains one per gap period, idx = next to release
//   RUN   | all domains out of reset, sequence complete
module rst_sequencer #(
    parameter int N_DOMAINS = 4,
    parameter int HOLD_CYC  = 16,
    parameter int GAP_CYC   = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    output logic [N_DOMAINS-1:0] o_rstn,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOMAINS - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        REL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [N_DOMAINS-1:0]   rstn_nx;
    logic                   busy_nx;
    logic                   done_nx;

    // Next-state and next-output decode; soft reset overrides sequencing.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        rstn_nx  = o_rstn;
        busy_nx  = o_busy;
        done_nx  = 1'b0;

        if (i_req) begin
            state_nx = HOLD;
            cnt_nx   = '0;
            idx_nx   = '0;
            rstn_nx  = '0;
            busy_nx  = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    rstn_nx = '0;
                    busy_nx = 1'b1;
                    if (cnt == HOLD_LAST) begin
                        cnt_nx     = '0;
                        rstn_nx[0] = 1'b1;
                        if (N_DOMAINS == 1) begin
                            idx_nx   = '0;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = RUN;
                        end else begin
                            idx_nx   = IDX_W'(1);
                            state_nx = REL;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                REL: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nx       = '0;
                        rstn_nx[idx] = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_nx   = '0;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = RUN;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                RUN: begin
                    cnt_nx  = '0;
                    idx_nx  = '0;
                    rstn_nx = '1;
                    busy_nx = 1'b0;
                end
                default: begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    rstn_nx  = '0;
                    busy_nx  = 1'b1;
                end
            endcase
        end
    end

    // State, counters and all outputs are registered; global reset wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            o_rstn <= '0;
            o_busy <= 1'b1;
            o_done <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            o_rstn <= rstn_nx;
            o_busy <= busy_nx;
            o_done <= done_nx;
        end
    end

endmodule
